adc_sample_filter: RTL and testbench
====================================

Name: adc_sample_filter

Overview:
Downstream consumer of the PWM sweep ADC. Detects each new conversion on the ADC's level-style ready flag and keeps a boxcar moving average over the last 2**LOG2_DEPTH samples. Publishes a smoothed, hysteresis-gated value with a one-cycle valid strobe for the MIDI player's control logic, such as volume or tempo.

Parameters:
WIDTH, 8, sample width in bits; matches the ADC data width.
LOG2_DEPTH, 2, log2 of the averaging window; window DEPTH = 2**LOG2_DEPTH samples, legal range 1..5.
HYST, 2, minimum absolute change in the average, in LSBs, before data_out updates.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
enable  input  1  when low, new samples are ignored and all state holds.
clear  input  1  synchronous flush: empties the window and returns to FILL.
drdy_in  input  1  ADC ready flag; level-style, may stay high for many cycles.
data_in  input  WIDTH  ADC result; valid whenever drdy_in is high.
data_out  output  WIDTH  filtered value.
out_valid  output  1  one-cycle pulse when data_out takes a new value.
settled  output  1  high while the window is full (RUN state).

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: data_out=0, out_valid=0, settled=0.
  - Internal state: sum=0, wr_ptr=0, fill_cnt=0, drdy_q=0, state=FILL.
  - Buffer contents are not reset.
- Edge detection:
  - drdy_q registers drdy_in every cycle, regardless of enable.
  - new_sample = drdy_in & ~drdy_q & enable.
  - A level held high yields exactly one sample.
  - A rise that occurs while enable=0 is lost. Re-enabling with drdy_in already high does not create a sample.
- Stage 1 (clock edge E0, where new_sample=1):
  - buf[wr_ptr] <= data_in.
  - wr_ptr increments and wraps from DEPTH-1 to 0.
  - FILL: sum <= sum + data_in; fill_cnt increments.
  - RUN: sum <= sum + data_in - buf[wr_ptr], where buf[wr_ptr] is the oldest sample and the read is combinational.
  - sum is WIDTH+LOG2_DEPTH bits wide, so overflow is impossible.
- Stage 2 (clock edge E1):
  - avg = sum >> LOG2_DEPTH (floor).
  - Entering RUN: when the DEPTH-th sample is written in FILL, state goes to RUN and settled=1. At E1, data_out <= avg and out_valid=1 unconditionally.
  - In RUN: if |avg - data_out| >= HYST, then data_out <= avg and out_valid=1. Otherwise out_valid=0 and data_out holds.
  - Total latency: out_valid is high during the cycle after E1, i.e. 2 edges after drdy_in is first sampled high.
- States:
  - FILL (fill_cnt < DEPTH): no out_valid.
  - RUN: continuous windowing.
  - No other states.
- clear=1:
  - state=FILL, sum=0, fill_cnt=0, wr_ptr=0, settled=0, and any pending stage-2 update is cancelled.
  - data_out holds its last value.
  - If clear coincides with new_sample, clear wins and the sample is dropped.
- Back-to-back samples (a rise every 2 cycles) are fully supported. The minimum drdy_in low time is 1 cycle.
- Reset mid-operation aborts immediately. After release, drdy_q=0, so a drdy_in already high counts as a new sample on the first enabled edge.

Optional Feature:
- Macro: ADC_FILTER_HYST_EN.
- Defined: hysteresis gating as described above.
- Undefined:
  - HYST is ignored.
  - Every stage-2 result in RUN drives data_out <= avg with out_valid=1, even if the value is unchanged.
  - No comparator or subtractor is synthesised.

Decomposition:
- Package adc_pkg:
  - localparam ADC_WIDTH = 8.
  - typedef logic [ADC_WIDTH-1:0] adc_sample_t.
  - typedef enum logic {FILL, RUN} adc_filt_state_t.
- Sub-module adc_window_buf:
  - DEPTH x WIDTH register array.
  - Write port plus combinational read of the oldest entry.
  - Owns wr_ptr and wrap logic.
- The top level holds edge detection, the sum, the FSM and the output stage.

Test Plan:
All cases use WIDTH=8, LOG2_DEPTH=2, HYST=2, with ADC_FILTER_HYST_EN defined.
- Reset:
  - Stimulus: hold reset=0 for 3 cycles while drdy_in toggles.
  - Required: data_out=0, out_valid=0, settled=0 throughout.
- Fill:
  - Stimulus: samples 10, 20, 30, 40, each with drdy_in held high for 5 cycles.
  - Required: no out_valid for the first three samples. After the fourth, exactly one out_valid, 2 edges after the rise, with data_out=25 and settled=1.
- Running average and hysteresis:
  - Stimulus: continue from Fill with samples 40, 30, 32.
  - Required: 40 gives data_out=32 with a pulse; 30 gives 35 with a pulse; 32 gives an average of 35, diff 0, so no pulse and data_out stays 35.
- Held level and enable:
  - Stimulus: drdy_in high for 50 cycles; separately, a rise while enable=0, then raise enable with drdy_in still high.
  - Required: one sample for the 50-cycle level. No sample in the enable case.
- Clear:
  - Stimulus: assert clear in RUN, coincident with a drdy_in rise carrying 200.
  - Required: sample dropped, settled=0, data_out holds 35, no out_valid until 4 new samples arrive.
- Async reset mid-window and feature off:
  - Stimulus: drop reset between stage 1 and stage 2.
  - Required: outputs are 0 immediately, with no pulse afterwards.
  - Stimulus: rebuild without ADC_FILTER_HYST_EN and repeat the Running average case.
  - Required: three out_valid pulses (32, 35, 35).

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types for the ADC sample filter: sample width, sample type and filter FSM states.
package adc_pkg;

    localparam int ADC_WIDTH = 8;

    typedef logic [ADC_WIDTH-1:0] adc_sample_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } adc_filt_state_t;

endpackage

// File: rtl/adc_window_buf.sv
// Circular sample window for the boxcar filter: one write port plus a combinational
// read of the oldest entry, which is the slot the next write will overwrite.
module adc_window_buf
    import adc_pkg::*;
#(
    parameter int WIDTH      = ADC_WIDTH,
    parameter int LOG2_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_oldest
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;

    // DEPTH is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + LOG2_DEPTH'(1);
        end
    end

    // Sample storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_oldest = r_mem[r_wr_ptr];

endmodule

// File: rtl/adc_sample_filter.sv
// Edge-detects the ADC ready level, keeps a 2**LOG2_DEPTH boxcar average and publishes it
// with a one-cycle valid pulse. Define ADC_FILTER_HYST_EN to gate updates by HYST LSBs.
//
// state | meaning
// FILL  | window not yet full; samples accumulate, no output
// RUN   | window full; each sample replaces the oldest and refreshes the average
module adc_sample_filter
    import adc_pkg::*;
#(
    parameter int WIDTH      = ADC_WIDTH,
    parameter int LOG2_DEPTH = 2,
    parameter int HYST       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             drdy_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             settled
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = WIDTH + LOG2_DEPTH;

    if (LOG2_DEPTH < 1 || LOG2_DEPTH > 5 || HYST < 0) begin : g_bad_param
        $error("adc_sample_filter: illegal parameter set");
    end

    logic            r_drdy_q;
    adc_filt_state_t r_state;
    logic [SW-1:0]   r_sum;
    logic [LOG2_DEPTH:0] r_fill_cnt;
    logic            r_pend;
    logic [WIDTH-1:0] r_data_out;
    logic            r_out_valid;

    logic            w_new_sample;
    logic            w_take;
    logic            w_last_fill;
    logic            w_update;
    logic [WIDTH-1:0] w_oldest;
    logic [WIDTH-1:0] w_avg;
    logic [SW-1:0]   w_sum_next;

    assign w_new_sample = drdy_in & ~r_drdy_q & enable;
    assign w_take       = w_new_sample & ~clear;
    assign w_last_fill  = (r_fill_cnt == (LOG2_DEPTH+1)'(DEPTH - 1));
    assign w_avg        = r_sum[SW-1:LOG2_DEPTH];

    adc_window_buf #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_window_buf (
        .clk       (clk),
        .rst_n     (reset),
        .i_wr_en   (w_take),
        .i_clear   (clear),
        .i_wr_data (data_in),
        .o_oldest  (w_oldest)
    );

    always_comb begin
        w_sum_next = r_sum + SW'(data_in);
        if (r_state == RUN) begin
            w_sum_next = w_sum_next - SW'(w_oldest);
        end
    end

`ifdef ADC_FILTER_HYST_EN
    logic             r_first;
    logic [WIDTH-1:0] w_diff;

    // The first average after filling is always published, whatever data_out held before.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_first <= 1'b0;
        end else if (clear) begin
            r_first <= 1'b0;
        end else begin
            r_first <= w_take && (r_state == FILL) && w_last_fill;
        end
    end

    assign w_diff   = (w_avg >= r_data_out) ? (w_avg - r_data_out) : (r_data_out - w_avg);
    assign w_update = r_first | (w_diff >= WIDTH'(HYST));
`else
    assign w_update = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drdy_q    <= 1'b0;
            r_state     <= FILL;
            r_sum       <= '0;
            r_fill_cnt  <= '0;
            r_pend      <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_drdy_q    <= drdy_in;
            r_out_valid <= 1'b0;
            r_pend      <= 1'b0;
            if (clear) begin
                r_state    <= FILL;
                r_sum      <= '0;
                r_fill_cnt <= '0;
            end else begin
                if (r_pend && w_update) begin
                    r_data_out  <= w_avg;
                    r_out_valid <= 1'b1;
                end
                if (w_take) begin
                    r_sum <= w_sum_next;
                    if (r_state == FILL) begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        if (w_last_fill) begin
                            r_state <= RUN;
                            r_pend  <= 1'b1;
                        end
                    end else begin
                        r_pend <= 1'b1;
                    end
                end
            end
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign settled   = (r_state == RUN);

endmodule

// File: tb/tb_adc_sample_filter.sv
// Self-checking bench for adc_sample_filter: a reference window model pushes expected
// pulses (value and cycle) into a queue; a monitor pops and compares on every out_valid.
module tb_adc_sample_filter;

`ifdef ADC_FILTER_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       enable  = 1'b0;
    logic       clear   = 1'b0;
    logic       drdy_in = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] data_out;
    logic       out_valid;
    logic       settled;

    adc_sample_filter #(
        .WIDTH      (8),
        .LOG2_DEPTH (2),
        .HYST       (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .drdy_in   (drdy_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .settled   (settled)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] val;
        int         due;
    } exp_t;

    exp_t q[$];

    int m_buf [4];
    int m_ptr  = 0;
    int m_fill = 0;
    int m_sum  = 0;
    int m_dout = 0;
    bit m_run  = 1'b0;

    task automatic model_flush();
        m_ptr  = 0;
        m_fill = 0;
        m_sum  = 0;
        m_run  = 1'b0;
    endtask

    task automatic model_sample(input logic [7:0] v);
        int   avg;
        int   diff;
        bit   push;
        exp_t e;
        push = 1'b0;
        if (!m_run) begin
            m_sum = m_sum + int'(v);
            m_buf[m_ptr] = int'(v);
            m_fill++;
            if (m_fill == 4) begin
                m_run = 1'b1;
                push  = 1'b1;
            end
        end else begin
            m_sum = m_sum + int'(v) - m_buf[m_ptr];
            m_buf[m_ptr] = int'(v);
            avg  = m_sum / 4;
            diff = (avg > m_dout) ? avg - m_dout : m_dout - avg;
            push = !HYST_EN || (diff >= 2);
        end
        m_ptr = (m_ptr + 1) % 4;
        if (push) begin
            m_dout = m_sum / 4;
            e.val  = 8'(m_dout);
            e.due  = cyc + 2;
            q.push_back(e);
        end
    endtask

    // One rising edge on drdy_in held for hi cycles, then low for lo extra cycles.
    task automatic send(input logic [7:0] v, input int hi, input int lo);
        @(negedge clk);
        data_in = v;
        drdy_in = 1'b1;
        if (enable && !clear) model_sample(v);
        repeat (hi) @(negedge clk);
        drdy_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: out_valid=1 data_out=%0d at cycle %0d, required no pulse",
                         data_out, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data_out !== e.val || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL pulse: data_out=%0d cycle=%0d, required data_out=%0d cycle=%0d",
                             data_out, cyc, e.val, e.due);
                end
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drdy_in = ~drdy_in;
            data_in = 8'(i * 40 + 7);
            n_cmp++;
            if (data_out !== 8'd0 || out_valid !== 1'b0 || settled !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: data_out=%0d out_valid=%b settled=%b, required 0/0/0",
                         data_out, out_valid, settled);
            end
        end
        @(negedge clk);
        drdy_in = 1'b0;
        enable  = 1'b1;
        reset   = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fill();
        send(8'd10, 5, 2);
        send(8'd20, 5, 2);
        send(8'd30, 5, 2);
        n_cmp++;
        if (settled !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_settled_early: settled=%b, required 0", settled);
        end
        send(8'd40, 5, 2);
        n_cmp++;
        if (settled !== 1'b1 || data_out !== 8'(m_dout)) begin
            n_bad++;
            $display("FAIL fill_done: settled=%b data_out=%0d, required 1/%0d", settled, data_out, m_dout);
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL fill_pending: %0d pulses missing, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_running();
        send(8'd40, 5, 2);
        send(8'd30, 5, 2);
        send(8'd32, 5, 2);
        n_cmp++;
        if (data_out !== 8'(m_dout)) begin
            n_bad++;
            $display("FAIL running_value: data_out=%0d, required %0d", data_out, m_dout);
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL running_pending: %0d pulses missing, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear   = 1'b1;
        drdy_in = 1'b1;
        data_in = 8'd200;
        model_flush();
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (settled !== 1'b0 || data_out !== 8'(m_dout)) begin
            n_bad++;
            $display("FAIL clear_state: settled=%b data_out=%0d, required 0/%0d", settled, data_out, m_dout);
        end
        repeat (3) @(negedge clk);
        drdy_in = 1'b0;
        repeat (4) @(negedge clk);
        send(8'd50, 3, 2);
        send(8'd60, 3, 2);
        send(8'd70, 3, 2);
        n_cmp++;
        if (settled !== 1'b0 || data_out !== 8'(m_dout)) begin
            n_bad++;
            $display("FAIL clear_refill: settled=%b data_out=%0d, required 0/%0d", settled, data_out, m_dout);
        end
        send(8'd80, 3, 2);
        n_cmp++;
        if (settled !== 1'b1 || data_out !== 8'(m_dout) || q.size() != 0) begin
            n_bad++;
            $display("FAIL clear_rerun: settled=%b data_out=%0d pending=%0d, required 1/%0d/0",
                     settled, data_out, q.size(), m_dout);
            q.delete();
        end
    endtask

    task automatic test_held_level();
        send(8'd100, 50, 3);
        n_cmp++;
        if (data_out !== 8'(m_dout) || q.size() != 0) begin
            n_bad++;
            $display("FAIL held_level: data_out=%0d pending=%0d, required %0d/0", data_out, q.size(), m_dout);
            q.delete();
        end
    endtask

    task automatic test_enable();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        drdy_in = 1'b1;
        data_in = 8'd5;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        drdy_in = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (data_out !== 8'(m_dout) || q.size() != 0) begin
            n_bad++;
            $display("FAIL enable_gate: data_out=%0d pending=%0d, required %0d/0", data_out, q.size(), m_dout);
            q.delete();
        end
        send(8'd90, 2, 2);
        n_cmp++;
        if (data_out !== 8'(m_dout) || q.size() != 0) begin
            n_bad++;
            $display("FAIL enable_resume: data_out=%0d pending=%0d, required %0d/0", data_out, q.size(), m_dout);
            q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [6];
        vals = '{8'd200, 8'd0, 8'd255, 8'd3, 8'd128, 8'd129};
        foreach (vals[i]) send(vals[i], 1, 0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (data_out !== 8'(m_dout) || q.size() != 0) begin
            n_bad++;
            $display("FAIL back_to_back: data_out=%0d pending=%0d, required %0d/0", data_out, q.size(), m_dout);
            q.delete();
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        data_in = 8'd150;
        drdy_in = 1'b1;
        model_sample(8'd150);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (data_out !== 8'd0 || out_valid !== 1'b0 || settled !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: data_out=%0d out_valid=%b settled=%b, required 0/0/0",
                     data_out, out_valid, settled);
        end
        q.delete();
        model_flush();
        m_dout = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_sample(8'd150);
        repeat (3) @(negedge clk);
        drdy_in = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (data_out !== 8'd0 || settled !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_quiet: data_out=%0d settled=%b, required 0/0", data_out, settled);
        end
        send(8'd150, 2, 2);
        send(8'd150, 2, 2);
        send(8'd150, 2, 2);
        n_cmp++;
        if (settled !== 1'b1 || data_out !== 8'(m_dout) || q.size() != 0) begin
            n_bad++;
            $display("FAIL post_reset_fill: settled=%b data_out=%0d pending=%0d, required 1/%0d/0",
                     settled, data_out, q.size(), m_dout);
            q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_running();
        test_clear();
        test_held_level();
        test_enable();
        test_back_to_back();
        test_async_reset();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
